uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART transmitter (uart_tx, 9600 baud) between NUM_REQ byte-stream requesters,
//  e.g. status byte, rx echo, IR-code forwarder. Round-robin grant, held for one frame
//  (until a byte flagged last). A byte register sits between the winner and uart_tx's valid/ready.
//  Enforces max frame length and an intra-frame stall timeout so no requester can lock the link.
// PARAMETERS
//  NUM_REQ        3        number of requesters (2..8)
//  DATA_W         8        byte width; matches uart_tx data_to_send
//  MAX_FRAME      16       max bytes per grant; forced release after the 16th accepted byte
//  STALL_CYCLES   500000   clk cycles (10 ms @ 50 MHz) of req_valid low inside a frame before abort
// PORTS
//  clk         in   1                 system clock (CLOCK_50)
//  rst_n       in   1                 asynchronous, active-low reset
//  req_valid   in   NUM_REQ           per-requester byte valid
//  req_data    in   NUM_REQ*DATA_W    flat; requester i at [i*DATA_W +: DATA_W]
//  req_last    in   NUM_REQ           byte is last of its frame
//  req_ready   out  NUM_REQ           per-requester accept (one-hot or zero)
//  tx_valid    out  1                 to uart_tx valid
//  tx_data     out  DATA_W            to uart_tx data_to_send
//  tx_ready    in   1                 from uart_tx ready
//  grant_id    out  $clog2(NUM_REQ)   current/last owner; for LEDs/debug
//  busy        out  1                 state != IDLE
//  frame_err   out  1                 1-cycle pulse on MAX_FRAME overrun or stall abort
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, tx_valid=0, tx_data=0, req_ready=0,
//   grant_id=NUM_REQ-1 (req 0 wins first), byte_cnt=0, stall_cnt=0, frame_err=0.
//  States: IDLE, STREAM, DRAIN.
//   IDLE: if |req_valid, pick first asserted index scanning from grant_id+1 (mod NUM_REQ).
//    Register it in grant_id. -> STREAM next cycle. No valid: stay.
//   STREAM: req_ready[grant_id] = (tx_valid==0); all others 0.
//    Accept = req_valid&req_ready. Next cycle: tx_data<=byte, tx_valid<=1, byte_cnt++, stall_cnt=0.
//    Accept with req_last=1 -> DRAIN.
//    Accept with byte_cnt==MAX_FRAME-1 and last=0 -> DRAIN, pulse frame_err.
//    req_valid[grant_id]=0 and tx_valid=0: stall_cnt++.
//     Reaching STALL_CYCLES-1 -> DRAIN, pulse frame_err.
//   DRAIN: req_ready=0. When tx_valid==0 (or tx_valid&tx_ready this cycle) -> IDLE.
//    byte_cnt=0 and stall_cnt=0 on leaving DRAIN.
//  Output register: tx_valid clears the cycle after tx_valid&tx_ready. tx_data is held stable while
//   tx_valid=1. No new load while tx_valid=1: max 1 byte per 2 clk, irrelevant at 9600 baud.
//  Latency: req_valid rises in IDLE @T -> grant_id/req_ready @T+1 -> tx_valid @T+2.
//  Fairness: grant_id stays at last owner through IDLE, so rotation is strictly round-robin.
//   A requester continuously valid waits at most NUM_REQ-1 frames.
//  Simultaneous events:
//   - tx_ready handshake and new accept in the same cycle: impossible by construction,
//     since accept requires tx_valid=0.
//   - last and MAX_FRAME boundary on the same byte: treat as normal last, no frame_err.
//   - Requester drops valid in IDLE before the grant cycle: grant is still issued.
//     STREAM then counts stall; the bench uses a small STALL_CYCLES.
//  Reset mid-frame: tx_valid drops immediately (async). The byte in flight inside uart_tx is
//   that module's concern. Requesters must restart their frame.
//  grant_id width: $clog2(NUM_REQ). Counters: byte_cnt $clog2(MAX_FRAME+1),
//   stall_cnt $clog2(STALL_CYCLES+1). All unsigned; no wrap (saturate at limit).
// STRUCTURE
//  uart_arb_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_STREAM, ARB_DRAIN} arb_state_e;
//   default parameter constants; function rr_next(req, last) for the bench model.
//  Sub-module rr_pick (combinational): inputs req[NUM_REQ], last_grant; outputs idx, found.
//   Rotate, priority-encode, rotate back.
//  Top: one always_ff (state, counters, output reg, grant) + one always_comb (next-state, req_ready).
// TESTING
//  1 Reset: hold rst_n=0 with all req_valid=1 -> tx_valid=0, req_ready=000, busy=0, grant_id=2.
//  2 Single frame: req1 sends A5,3C(last), tx_ready pulses 1 cycle after each tx_valid
//    -> tx_data A5 then 3C, grant_id=1, busy low 1 cycle after 2nd handshake.
//  3 Round robin: req0,1,2 all valid with 1-byte frames (last=1), data 10/11/12
//    -> tx order 10,11,12,10, grant_id 0,1,2,0.
//  4 Overrun: MAX_FRAME=4, req0 streams 6 bytes, last never set
//    -> 4 bytes out, frame_err pulse, then grant moves to the next valid requester.
//  5 Stall: STALL_CYCLES=20, req2 sends 1 byte then drops valid
//    -> frame_err at 20 idle cycles, busy=0 once tx drains.
//  6 Back-pressure + reset: tx_ready held 0 for 100 cycles -> tx_data stable, req_ready=0;
//    then assert rst_n=0 mid-frame -> tx_valid=0 same cycle, state IDLE after release.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE, STREAM, DRAIN)
//   DEF_*       : default parameter values for uart_tx_arbiter
//   rr_next     : round-robin "who is next" helper, integer based, for models
package uart_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_STREAM = 2'd1,
        ARB_DRAIN  = 2'd2
    } arb_state_e;

    localparam int DEF_NUM_REQ      = 3;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_MAX_FRAME    = 16;
    localparam int DEF_STALL_CYCLES = 500000;

    // First requester with its bit set in req, scanning from last+1 upward
    // (wrapping at num_req). Returns last when nobody is requesting.
    function automatic int rr_next(input logic [7:0] req, input int last, input int num_req);
        logic [7:0] s;
        rr_next = last;
        for (int k = num_req; k >= 1; k--) begin
            s = req >> ((last + k) % num_req);
            if (s[0]) rr_next = (last + k) % num_req;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req        : request vector, one bit per requester
//   last_grant : index of the previous owner; the scan starts just after it
//   idx        : chosen requester (valid only when found)
//   found      : at least one request bit is set
// The request vector is doubled so a plain part-select performs the rotation;
// a fixed priority encoder then finds the first hit and the offset is added
// back to the start position (one conditional subtract replaces a modulo).
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int GW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [GW-1:0]      idx,
    output logic               found
);

    localparam logic [GW:0] N_W = (GW+1)'(NUM_REQ);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [GW:0]          start;
    logic [GW:0]          off;
    logic [GW:0]          sum;

    always_comb begin
        dbl   = {req, req};
        start = {1'b0, last_grant} + 1'b1;
        rot   = dbl[start +: NUM_REQ];
        off   = '0;
        found = 1'b0;
        // Descending scan so the lowest rotated position wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off   = (GW+1)'(k);
                found = 1'b1;
            end
        end
        sum = start + off;
        if (sum >= N_W) sum = sum - N_W;
        idx = sum[GW-1:0];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams.
// A grant lasts one frame: until a byte flagged last, MAX_FRAME bytes, or
// STALL_CYCLES cycles without data from the owner (the last two pulse frame_err).
// Ports:
//   clk, rst_n            system clock (CLOCK_50), async active-low reset
//   req_valid/req_data/   per-requester byte stream; requester i's byte sits at
//   req_last/req_ready      req_data[i*DATA_W +: DATA_W]
//   tx_valid/tx_data/     single-byte output register towards uart_tx
//   tx_ready
//   grant_id              current or most recent owner
//   busy                  FSM not in IDLE
//   frame_err             one-cycle pulse on overrun or stall abort
//   state_dbg             raw FSM state for debug/checkers
// Handshakes: a byte moves on any clock edge where valid and ready are both 1;
// valid never waits for ready, and while valid is 1 the data is held stable.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_FRAME    = DEF_MAX_FRAME,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_ready,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy,
    output logic                        frame_err,
    output arb_state_e                  state_dbg
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_FRAME + 1);
    localparam int SW = $clog2(STALL_CYCLES + 1);

    localparam logic [BW-1:0] BYTE_LAST  = BW'(MAX_FRAME - 1);
    localparam logic [BW-1:0] BYTE_MAX   = BW'(MAX_FRAME);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_CYCLES);

    arb_state_e          state, next_state;
    logic [BW-1:0]       byte_cnt;
    logic [SW-1:0]       stall_cnt;
    logic [GW-1:0]       pick_idx;
    logic                pick_found;
    logic                cur_valid, cur_last;
    logic                accept, stall_tick, overrun, stall_abort;
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (grant_id),
        .idx        (pick_idx),
        .found      (pick_found)
    );

    assign cur_valid = req_valid[grant_id];
    assign cur_last  = req_last[grant_id];
    assign busy      = (state != ARB_IDLE);
    assign state_dbg = state;

    always_comb begin
        next_state  = state;
        req_ready   = '0;
        accept      = 1'b0;
        stall_tick  = 1'b0;
        overrun     = 1'b0;
        stall_abort = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_found) next_state = ARB_STREAM;
            end
            ARB_STREAM: begin
                // Only an empty output register can take a byte.
                if (!tx_valid) req_ready[grant_id] = 1'b1;
                accept     = cur_valid && !tx_valid;
                stall_tick = !cur_valid && !tx_valid;
                if (accept) begin
                    // A last byte landing exactly on the limit is a clean end.
                    if (cur_last) begin
                        next_state = ARB_DRAIN;
                    end else if (byte_cnt == BYTE_LAST) begin
                        next_state = ARB_DRAIN;
                        overrun    = 1'b1;
                    end
                end else if (stall_tick && stall_cnt == STALL_LAST) begin
                    next_state  = ARB_DRAIN;
                    stall_abort = 1'b1;
                end
            end
            ARB_DRAIN: begin
                if (!tx_valid || tx_ready) next_state = ARB_IDLE;
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            grant_id  <= GW'(NUM_REQ - 1);
            byte_cnt  <= '0;
            stall_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= next_state;
            frame_err <= overrun | stall_abort;

            if (state == ARB_IDLE && pick_found) grant_id <= pick_idx;

            if (tx_valid && tx_ready) tx_valid <= 1'b0;

            // accept implies tx_valid==0, so it never collides with the clear above.
            if (accept) begin
                tx_data   <= data_arr[grant_id];
                tx_valid  <= 1'b1;
                stall_cnt <= '0;
                if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + 1'b1;
            end else if (stall_tick && stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (state == ARB_DRAIN && next_state == ARB_IDLE) begin
                byte_cnt  <= '0;
                stall_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (3 requesters, MAX_FRAME=4, STALL_CYCLES=20).
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int NUM_REQ      = 3;
    localparam int DATA_W       = 8;
    localparam int MAX_FRAME    = 4;
    localparam int STALL_CYCLES = 20;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_valid;
    logic [DATA_W-1:0]         tx_data;
    logic                      tx_ready;
    logic [1:0]                grant_id;
    logic                      busy;
    logic                      frame_err;
    arb_state_e                state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int model_last;
    int exp_err;

    // Per-requester byte streams: {last, data}.
    logic [8:0] src_q [NUM_REQ][$];
    // Scoreboard: {owner, data} for every byte uart_tx should receive, in order.
    logic [9:0] exp_q[$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .MAX_FRAME    (MAX_FRAME),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant_id  (grant_id),
        .busy      (busy),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i] = v;
        req_data[i*DATA_W +: DATA_W] = d;
        req_last[i] = l;
    endtask

    task automatic add_frame(input int r, input int len);
        for (int j = 0; j < len; j++)
            src_q[r].push_back({(j == len - 1), 8'($urandom)});
    endtask

    // Reference model: each grant goes to the next non-empty stream after the
    // previous owner and takes bytes until one flagged last or MAX_FRAME bytes.
    task automatic build_model();
        logic [8:0] m_q [NUM_REQ][$];
        logic [8:0] b;
        int o, cnt;
        bit frame_done;
        exp_q.delete();
        exp_err = 0;
        for (int i = 0; i < NUM_REQ; i++) m_q[i] = src_q[i];
        o = 0;
        while (o >= 0) begin
            o = -1;
            for (int k = 1; k <= NUM_REQ; k++)
                if (o < 0 && m_q[(model_last + k) % NUM_REQ].size() > 0) o = (model_last + k) % NUM_REQ;
            if (o >= 0) begin
                cnt = 0;
                frame_done = 1'b0;
                while (!frame_done) begin
                    b = m_q[o].pop_front();
                    cnt++;
                    exp_q.push_back({o[1:0], b[7:0]});
                    if (b[8]) begin
                        frame_done = 1'b1;
                    end else if (cnt == MAX_FRAME) begin
                        exp_err++;
                        frame_done = 1'b1;
                    end
                end
                model_last = o;
            end
        end
    endtask

    // Streams src_q into the DUT with a randomly-ready sink until everything
    // has drained, checking every byte against the scoreboard.
    task automatic run_auto(input string name);
        int cyc = 0;
        int obs_err = 0;
        int bad_ready = 0;
        bit done = 1'b0;
        bit all_empty;
        logic [9:0] e;
        logic [NUM_REQ-1:0] own;
        while (!done && cyc < 5000) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() > 0) set_req(i, 1'b1, src_q[i][0][7:0], src_q[i][0][8]);
                else set_req(i, 1'b0, 8'h00, 1'b0);
            end
            tx_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (frame_err) obs_err++;
            own = '0;
            own[grant_id] = 1'b1;
            if ((req_ready & ~own) != '0) bad_ready++;
            for (int i = 0; i < NUM_REQ; i++)
                if (req_valid[i] && req_ready[i]) void'(src_q[i].pop_front());
            if (tx_valid && tx_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL %s_extra_byte: got grant %0d data %h, want no byte", name, grant_id, tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({grant_id, tx_data} !== e) begin
                        n_bad++;
                        $display("FAIL %s_byte: got grant %0d data %h, want grant %0d data %h",
                                 name, grant_id, tx_data, e[9:8], e[7:0]);
                    end
                end
            end
            all_empty = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) if (src_q[i].size() > 0) all_empty = 1'b0;
            done = all_empty && exp_q.size() == 0 && !busy && !tx_valid;
            cyc++;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_drain: got %0d bytes outstanding after %0d cycles, want 0", name, exp_q.size(), cyc);
        end
        n_cmp++;
        if (obs_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s_frame_err: got %0d pulses, want %0d", name, obs_err, exp_err);
        end
        n_cmp++;
        if (bad_ready !== 0) begin
            n_bad++;
            $display("FAIL %s_ready_owner: got %0d cycles with foreign req_ready, want 0", name, bad_ready);
        end
        for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
        exp_q.delete();
        req_valid = '0;
        tx_ready  = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_last  = '0;
        req_data  = 24'($urandom);
        tx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL reset_grant: got %0d want 2", grant_id); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        req_valid = '0;
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        set_req(1, 1'b1, 8'hA5, 1'b0);
        tx_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant: got %0d want 1", grant_id); end
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL single_ready1: got %b want 010", req_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
        @(negedge clk);
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'hA5}) begin n_bad++; $display("FAIL single_byte0: got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
        n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL single_ready_full: got %b want 000", req_ready); end
        set_req(1, 1'b1, 8'h3C, 1'b1);
        tx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_clear: got %b want 0", tx_valid); end
        n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL single_ready2: got %b want 010", req_ready); end
        tx_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL single_byte1: got v=%b d=%h want v=1 d=3c", tx_valid, tx_data); end
        n_cmp++; if (state_dbg !== ARB_DRAIN) begin n_bad++; $display("FAIL single_drain: got %0d want %0d", state_dbg, ARB_DRAIN); end
        req_valid = '0;
        tx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle: got busy %b want 0", busy); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL single_done_valid: got %b want 0", tx_valid); end
        n_cmp++; if (grant_id !== 2'd1) begin n_bad++; $display("FAIL single_grant_hold: got %0d want 1", grant_id); end
        tx_ready = 1'b0;
        model_last = 1;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int i = 0; i < NUM_REQ; i++)
                src_q[i].push_back({1'b1, 8'(8'h10 + i)});
        build_model();
        run_auto("round_robin");
    endtask

    task automatic test_overrun();
        add_frame(0, 6);
        add_frame(1, 1);
        add_frame(2, MAX_FRAME);
        build_model();
        run_auto("overrun");
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NUM_REQ; i++)
                for (int f = $urandom_range(0, 2); f > 0; f--)
                    add_frame(i, $urandom_range(1, 6));
            build_model();
            run_auto("random");
        end
    endtask

    task automatic test_stall();
        logic [7:0] d;
        int stalls = 0;
        int cyc = 0;
        bit seen = 1'b0;
        d = 8'($urandom);
        req_valid = '0;
        set_req(2, 1'b1, d, 1'b0);
        tx_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({grant_id, req_ready} !== {2'd2, 3'b100}) begin n_bad++; $display("FAIL stall_grant: got g=%0d r=%b want g=2 r=100", grant_id, req_ready); end
        @(negedge clk);
        n_cmp++; if ({tx_valid, tx_data} !== {1'b1, d}) begin n_bad++; $display("FAIL stall_byte: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, d); end
        req_valid = '0;
        if (!tx_valid) stalls++;
        while (!seen && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (frame_err) seen = 1'b1;
            else if (!tx_valid) stalls++;
        end
        n_cmp++; if (!seen || stalls != STALL_CYCLES) begin n_bad++; $display("FAIL stall_abort: got pulse=%b after %0d stall cycles, want pulse after %0d", seen, stalls, STALL_CYCLES); end
        @(negedge clk);
        n_cmp++; if ({frame_err, busy} !== 2'b00) begin n_bad++; $display("FAIL stall_release: got err=%b busy=%b want 0 0", frame_err, busy); end
        tx_ready = 1'b0;
        model_last = 2;
    endtask

    task automatic test_backpressure_reset();
        logic [7:0] d0;
        int bad = 0;
        d0 = 8'($urandom);
        set_req(0, 1'b1, d0, 1'b0);
        tx_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if ({grant_id, req_ready} !== {2'd0, 3'b001}) begin n_bad++; $display("FAIL bp_grant: got g=%0d r=%b want g=0 r=001", grant_id, req_ready); end
        @(negedge clk);
        set_req(0, 1'b1, ~d0, 1'b0);
        repeat (100) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== d0 || req_ready !== 3'b000) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles want 0 (data %h)", bad, d0); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({tx_valid, busy, req_ready} !== 5'b0) begin n_bad++; $display("FAIL bp_async_reset: got v=%b busy=%b r=%b want 0 0 000", tx_valid, busy, req_ready); end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (state_dbg !== ARB_IDLE || grant_id !== 2'd2) begin n_bad++; $display("FAIL bp_after_reset: got state %0d grant %0d want %0d 2", state_dbg, grant_id, ARB_IDLE); end
        model_last = NUM_REQ - 1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_overrun();
        test_random();
        test_stall();
        test_backpressure_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
